// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III slave engine.
package z3_pkg;

  localparam int unsigned ZIII_SPACE_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    END   = 2'd3
  } z3_state_e;

endpackage

// File: rtl/z3_region_decode.sv
// Combinational sub-region compare with lowest-index-wins priority encode.
module z3_region_decode
  import z3_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned OFS_W       = 28,
  parameter int unsigned IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [OFS_W-1:0]             addr_ofs,
  input  logic [NUM_REGIONS*OFS_W-1:0] region_base,
  input  logic [NUM_REGIONS*OFS_W-1:0] region_mask,
  output logic                         hit_c,
  output logic [NUM_REGIONS-1:0]       sel_c,
  output logic [IDX_W-1:0]             idx_c
);

  // Walk from the top index down so the lowest matching region overrides.
  always_comb begin
    hit_c = 1'b0;
    sel_c = '0;
    idx_c = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (((addr_ofs ^ region_base[i*OFS_W +: OFS_W]) & region_mask[i*OFS_W +: OFS_W]) == '0) begin
        hit_c    = 1'b1;
        sel_c    = '0;
        sel_c[i] = 1'b1;
        idx_c    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/z3_slave_engine.sv
// Zorro III slave cycle engine: address decode, wait states, DTACK generation.
// Optional multiple-transfer (burst) support is built when Z3_BURST_EN is defined.
module z3_slave_engine
  import z3_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned OFS_W       = 28,
  parameter int unsigned WAIT_W      = 4
) (
  input  logic                          CLK_50M,
  input  logic                          IORST_n,
  input  logic                          FCS_n,
  input  logic [31:0]                   A,
  input  logic [2:0]                    FC,
  input  logic                          READ,
  input  logic [3:0]                    DS_n,
  input  logic                          DOE,
  input  logic                          MTCR_n,
  input  logic                          configured,
  input  logic [ZIII_SPACE_BITS-1:0]    base_addr,
  input  logic [NUM_REGIONS*OFS_W-1:0]  region_base,
  input  logic [NUM_REGIONS*OFS_W-1:0]  region_mask,
  input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
  output logic                          dtack_oe,
  output logic                          MTACK_n,
  output logic [NUM_REGIONS-1:0]        sel,
  output logic [OFS_W-1:0]              ofs,
  output logic                          rd_stb,
  output logic                          wr_stb
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic                   fcs_m, fcs_s;
  z3_state_e              state, state_nxt;
  logic [WAIT_W-1:0]      cnt, cnt_nxt, wait_q, wait_nxt;
  logic                   dtack_nxt, mtack_nxt, rd_nxt, wr_nxt;
  logic [NUM_REGIONS-1:0] sel_nxt;
  logic [OFS_W-1:0]       ofs_nxt;

  logic                   dec_hit_c;
  logic [NUM_REGIONS-1:0] dec_sel_c;
  logic [IDX_W-1:0]       dec_idx_c;
  logic                   hit_c;
  logic                   unused_ok;

  assign unused_ok = ^{FC[2], MTCR_n};

  z3_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .OFS_W       (OFS_W),
    .IDX_W       (IDX_W)
  ) u_decode (
    .addr_ofs    (A[OFS_W-1:0]),
    .region_base (region_base),
    .region_mask (region_mask),
    .hit_c       (dec_hit_c),
    .sel_c       (dec_sel_c),
    .idx_c       (dec_idx_c)
  );

  assign hit_c = configured && (A[31 -: ZIII_SPACE_BITS] == base_addr) &&
                 (FC[1] ^ FC[0]) && dec_hit_c;

  // Two-flop synchroniser; idles high so a reset looks like "no cycle".
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_m <= 1'b1;
      fcs_s <= 1'b1;
    end else begin
      fcs_m <= FCS_n;
      fcs_s <= fcs_m;
    end
  end

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wait_q   <= '0;
      dtack_oe <= 1'b0;
      MTACK_n  <= 1'b1;
      sel      <= '0;
      ofs      <= '0;
      rd_stb   <= 1'b0;
      wr_stb   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_q   <= wait_nxt;
      dtack_oe <= dtack_nxt;
      MTACK_n  <= mtack_nxt;
      sel      <= sel_nxt;
      ofs      <= ofs_nxt;
      rd_stb   <= rd_nxt;
      wr_stb   <= wr_nxt;
    end
  end

  // Next-state and next-output logic; strobes default low so they pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_nxt  = wait_q;
    dtack_nxt = dtack_oe;
    mtack_nxt = MTACK_n;
    sel_nxt   = sel;
    ofs_nxt   = ofs;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    if (fcs_s) begin
      state_nxt = IDLE;
      dtack_nxt = 1'b0;
      sel_nxt   = '0;
      mtack_nxt = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          dtack_nxt = 1'b0;
          sel_nxt   = '0;
          if (hit_c) begin
            state_nxt = START;
            ofs_nxt   = A[OFS_W-1:0];
            sel_nxt   = dec_sel_c;
            wait_nxt  = region_wait[dec_idx_c*WAIT_W +: WAIT_W];
            cnt_nxt   = region_wait[dec_idx_c*WAIT_W +: WAIT_W];
          end
        end
        START: begin
`ifdef Z3_BURST_EN
          mtack_nxt = MTCR_n;
`endif
          if (READ || ((DS_n != 4'hF) && DOE)) begin
            state_nxt = DATA;
            rd_nxt    = READ;
            wr_nxt    = !READ;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            state_nxt = END;
            dtack_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        END: begin
`ifdef Z3_BURST_EN
          // Next beat: master released the strobes but keeps requesting.
          if ((DS_n == 4'hF) && !MTCR_n && !MTACK_n) begin
            state_nxt    = DATA;
            dtack_nxt    = 1'b0;
            ofs_nxt[7:2] = A[7:2];
            cnt_nxt      = wait_q;
            rd_nxt       = READ;
            wr_nxt       = !READ;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z3_slave_engine.sv
// Scoreboard bench for z3_slave_engine; burst checks follow Z3_BURST_EN.
module tb_z3_slave_engine;

  typedef struct packed {
    logic        rd;
    logic [3:0]  sel;
    logic [27:0] ofs;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fcs_n;
  logic [31:0]  a;
  logic [2:0]   fc;
  logic         read;
  logic [3:0]   ds_n;
  logic         doe;
  logic         mtcr_n;
  logic         configured;
  logic [3:0]   base_addr;
  logic [111:0] region_base;
  logic [111:0] region_mask;
  logic [15:0]  region_wait;
  logic         dtack_oe;
  logic         mtack_n;
  logic [3:0]   sel;
  logic [27:0]  ofs;
  logic         rd_stb;
  logic         wr_stb;

  int   npass  = 0;
  int   ntotal = 0;
  exp_t sb_q[$];

  always #10 clk = ~clk;

  z3_slave_engine dut (
    .CLK_50M     (clk),
    .IORST_n     (rst_n),
    .FCS_n       (fcs_n),
    .A           (a),
    .FC          (fc),
    .READ        (read),
    .DS_n        (ds_n),
    .DOE         (doe),
    .MTCR_n      (mtcr_n),
    .configured  (configured),
    .base_addr   (base_addr),
    .region_base (region_base),
    .region_mask (region_mask),
    .region_wait (region_wait),
    .dtack_oe    (dtack_oe),
    .MTACK_n     (mtack_n),
    .sel         (sel),
    .ofs         (ofs),
    .rd_stb      (rd_stb),
    .wr_stb      (wr_stb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every strobe pulse must match the oldest expected beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rd_stb || wr_stb)) begin
      if (sb_q.size() == 0) begin
        check("strobe_unexpected", {rd_stb, wr_stb}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", {rd_stb, wr_stb}, {e.rd, !e.rd});
        check("strobe_sel", 32'(sel), 32'(e.sel));
        check("strobe_ofs", 32'(ofs), 32'(e.ofs));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full cycle; exp_lat=0 means a miss that must stay silent for 20 edges.
  task automatic run_cycle(input string name, input logic [31:0] addr, input logic rd,
                           input logic [3:0] exp_sel, input int exp_lat);
    int n;
    int lim;
    exp_t e;
    @(posedge clk); #1;
    a    = addr;
    read = rd;
    ds_n = rd ? 4'hF : 4'h0;
    doe  = !rd;
    if (exp_sel != 4'b0000) begin
      e = '{rd: rd, sel: exp_sel, ofs: addr[27:0]};
      sb_q.push_back(e);
    end
    fcs_n = 1'b0;
    n   = 0;
    lim = (exp_lat == 0) ? 20 : 40;
    while (n < lim && !dtack_oe) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, dtack_oe ? n : 0, exp_lat);
    check({name, "_sel"}, 32'(sel), 32'(exp_sel));
    fcs_n = 1'b1;
    ds_n  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_idle"}, {dtack_oe, sel, mtack_n}, {1'b0, 4'b0000, 1'b1});
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_n       = 1'b0;
    fcs_n       = 1'b1;
    a           = '0;
    fc          = 3'b101;
    read        = 1'b1;
    ds_n        = 4'hF;
    doe         = 1'b0;
    mtcr_n      = 1'b1;
    configured  = 1'b1;
    base_addr   = 4'h4;
    region_base = {28'h000_0000, 28'h100_0000, 28'h080_0000, 28'h000_0000};
    region_mask = {28'h000_0000, 28'hF80_0000, 28'hF80_0000, 28'hF80_0000};
    region_wait = {4'd0, 4'd2, 4'd0, 4'd1};
    #25;
    check("reset_outputs", {dtack_oe, mtack_n, sel, rd_stb, wr_stb}, {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0});
    check("reset_ofs", 32'(ofs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cycle("rd_r1_w0", 32'h4080_0000, 1'b1, 4'b0010, 5);
    run_cycle("rd_r0_w1", 32'h4000_0000, 1'b1, 4'b0001, 6);
    run_cycle("rd_r2_w2", 32'h4100_0000, 1'b1, 4'b0100, 7);
    run_cycle("rd_r3_w0", 32'h4F00_0000, 1'b1, 4'b1000, 5);
    run_cycle("wr_r1_w0", 32'h4080_0010, 1'b0, 4'b0010, 5);
    run_cycle("miss_base", 32'h5000_0000, 1'b1, 4'b0000, 0);
    configured = 1'b0;
    run_cycle("miss_unconf", 32'h4080_0000, 1'b1, 4'b0000, 0);
    configured = 1'b1;
    fc = 3'b011;
    run_cycle("miss_fc", 32'h4080_0000, 1'b1, 4'b0000, 0);
    fc = 3'b101;

    // Wait-state change after the latch must not affect the running cycle.
    fork
      begin
        repeat (4) @(posedge clk);
        #2 region_wait[7:4] = 4'd3;
      end
    join_none
    run_cycle("cfg_mid_cycle", 32'h4080_0000, 1'b1, 4'b0010, 5);
    run_cycle("rd_r1_w3", 32'h4080_0000, 1'b1, 4'b0010, 8);

    // Abort in DATA with a long wait count.
    region_wait[7:4] = 4'd15;
    @(posedge clk); #1;
    a = 32'h4080_0000; read = 1'b1;
    e = '{rd: 1'b1, sel: 4'b0010, ofs: 28'h080_0000};
    sb_q.push_back(e);
    fcs_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_in_data", {dtack_oe, sel}, {1'b0, 4'b0010});
    fcs_n = 1'b1;
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dtack_oe) n++;
    end
    check("abort_idle", {dtack_oe, sel, mtack_n}, {1'b0, 4'b0000, 1'b1});
    repeat (20) begin
      @(posedge clk); #1;
      if (dtack_oe) n++;
    end
    check("abort_no_dtack", n, 0);
    region_wait[7:4] = 4'd0;

`ifdef Z3_BURST_EN
    // Four-beat read burst, A[7:2] = 0..3.
    @(posedge clk); #1;
    a = 32'h4080_0000; read = 1'b1; ds_n = 4'h0; mtcr_n = 1'b0;
    e = '{rd: 1'b1, sel: 4'b0010, ofs: 28'h080_0000};
    sb_q.push_back(e);
    fcs_n = 1'b0;
    n = 0;
    while (n < 40 && !dtack_oe) begin
      @(posedge clk); #1;
      n++;
    end
    check("burst_first_latency", dtack_oe ? n : 0, 5);
    check("burst_mtack_first", mtack_n, 1'b0);
    for (int b = 1; b < 4; b++) begin
      a = 32'h4080_0000 | 32'(b << 2);
      e = '{rd: 1'b1, sel: 4'b0010, ofs: 28'h080_0000 | 28'(b << 2)};
      sb_q.push_back(e);
      ds_n = 4'hF;
      @(posedge clk); #1;
      check("burst_beat_data", {dtack_oe, mtack_n}, {1'b0, 1'b0});
      ds_n = 4'h0;
      @(posedge clk); #1;
      check("burst_beat_end", {dtack_oe, mtack_n}, {1'b1, 1'b0});
      check("burst_ofs", 32'(ofs[7:2]), 32'(b));
    end
    fcs_n = 1'b1; mtcr_n = 1'b1; ds_n = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("burst_idle", {dtack_oe, mtack_n, sel}, {1'b0, 1'b1, 4'b0000});
`else
    // Without burst support END holds and MTACK_n never asserts.
    @(posedge clk); #1;
    a = 32'h4080_0000; read = 1'b1; ds_n = 4'h0; mtcr_n = 1'b0;
    e = '{rd: 1'b1, sel: 4'b0010, ofs: 28'h080_0000};
    sb_q.push_back(e);
    fcs_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("nb_dtack", {dtack_oe, mtack_n}, {1'b1, 1'b1});
    ds_n = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    check("nb_end_holds", {dtack_oe, mtack_n, rd_stb}, {1'b1, 1'b1, 1'b0});
    fcs_n = 1'b1; mtcr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("nb_idle", {dtack_oe, mtack_n}, {1'b0, 1'b1});
`endif

    // Reset in END: everything returns to reset values at once.
    @(posedge clk); #1;
    a = 32'h4080_0000; read = 1'b1; ds_n = 4'h0;
    e = '{rd: 1'b1, sel: 4'b0010, ofs: 28'h080_0000};
    sb_q.push_back(e);
    fcs_n = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_dtack", dtack_oe, 1'b1);
    rst_n = 1'b0;
    fcs_n = 1'b1;
    #1;
    check("async_reset_outputs", {dtack_oe, mtack_n, sel, rd_stb, wr_stb}, {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0});
    check("async_reset_ofs", 32'(ofs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dtack_oe) n++;
    end
    check("post_reset_no_dtack", n, 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
